// File: rtl/tlb_ctrl.sv
// TLB management controller: sequences SRCH/RD/WR/FILL/INV requests over a 3-state FSM.
// Optional build macro TLB_FILL_LFSR_EN selects an LFSR fill index instead of a round-robin counter.
module tlb_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [4:0]  req_inv_op,
    input  logic [9:0]  req_asid,
    input  logic [31:0] req_va,
    input  logic [31:0] csr_tlbidx,
    input  logic [18:0] csr_tlbehi_vppn,
    input  logic [31:0] csr_tlbelo0,
    input  logic [31:0] csr_tlbelo1,
    input  logic [9:0]  csr_asid,
    output logic [18:0] tlb_s_vppn,
    output logic        tlb_s_va_bit12,
    output logic [9:0]  tlb_s_asid,
    input  logic        tlb_s_found,
    input  logic [3:0]  tlb_s_index,
    output logic        tlb_we,
    output logic [3:0]  tlb_w_index,
    output logic [88:0] tlb_w_entry,
    output logic [3:0]  tlb_r_index,
    input  logic [88:0] tlb_r_entry,
    output logic        tlb_inv_valid,
    output logic [4:0]  tlb_inv_op,
    output logic        resp_valid,
    output logic [2:0]  resp_op,
    output logic        resp_ne,
    output logic [3:0]  resp_index,
    output logic [88:0] resp_entry,
    output logic        resp_err
);
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_EXEC = 2'd1, ST_RESP = 2'd2} state_t;

    localparam logic [2:0] OP_SRCH = 3'd0;
    localparam logic [2:0] OP_RD   = 3'd1;
    localparam logic [2:0] OP_WR   = 3'd2;
    localparam logic [2:0] OP_FILL = 3'd3;
    localparam logic [2:0] OP_INV  = 3'd4;

    function automatic logic [88:0] pack_entry(input logic e, input logic [18:0] vppn,
                                               input logic [5:0] ps, input logic [9:0] asid,
                                               input logic [27:0] lo0, input logic [27:0] lo1);
        return {e, vppn, ps, asid, lo0[6] & lo1[6],
                lo0[27:8], lo0[3:2], lo0[5:4], lo0[1], lo0[0],
                lo1[27:8], lo1[3:2], lo1[5:4], lo1[1], lo1[0]};
    endfunction

    state_t        state_r, state_nxt_s;
    logic [2:0]    op_r;
    logic [4:0]    inv_op_r;
    logic [9:0]    asid_r, cur_asid_r;
    logic [19:0]   va_hi_r;
    logic [3:0]    idx_r, fill_idx_r;
    logic [18:0]   vppn_r;
    logic [88:0]   wentry_r;
    logic          res_ne_s, res_err_s;
    logic [3:0]    res_index_s;
    logic [88:0]   res_entry_s;

    assign req_ready = (state_r == ST_IDLE);

    // State register, request/CSR capture and registered response
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            op_r       <= 3'd0;
            inv_op_r   <= 5'd0;
            asid_r     <= 10'd0;
            cur_asid_r <= 10'd0;
            va_hi_r    <= 20'd0;
            idx_r      <= 4'd0;
            vppn_r     <= 19'd0;
            wentry_r   <= 89'd0;
            resp_valid <= 1'b0;
            resp_op    <= 3'd0;
            resp_ne    <= 1'b0;
            resp_index <= 4'd0;
            resp_entry <= 89'd0;
            resp_err   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            if (state_r == ST_IDLE && req_valid) begin
                op_r       <= req_op;
                inv_op_r   <= req_inv_op;
                asid_r     <= req_asid;
                cur_asid_r <= csr_asid;
                va_hi_r    <= req_va[31:12];
                idx_r      <= csr_tlbidx[3:0];
                vppn_r     <= csr_tlbehi_vppn;
                wentry_r   <= pack_entry(~csr_tlbidx[31], csr_tlbehi_vppn, csr_tlbidx[29:24],
                                         csr_asid, csr_tlbelo0[27:0], csr_tlbelo1[27:0]);
            end
            if (state_r == ST_EXEC) begin
                resp_valid <= 1'b1;
                resp_op    <= op_r;
                resp_ne    <= res_ne_s;
                resp_index <= res_index_s;
                resp_entry <= res_entry_s;
                resp_err   <= res_err_s;
            end else begin
                resp_valid <= 1'b0;
            end
        end
    end

`ifdef TLB_FILL_LFSR_EN
    // Free-running x^4+x^3+1 LFSR supplying the fill index
    always_ff @(posedge clk) begin
        if (reset) begin
            fill_idx_r <= 4'b0001;
        end else begin
            fill_idx_r <= {fill_idx_r[2:0], fill_idx_r[3] ^ fill_idx_r[2]};
        end
    end
`else
    // Round-robin fill index, advanced once per executed FILL
    always_ff @(posedge clk) begin
        if (reset) begin
            fill_idx_r <= 4'd0;
        end else if (state_r == ST_EXEC && op_r == OP_FILL) begin
            fill_idx_r <= fill_idx_r + 4'd1;
        end else begin
            fill_idx_r <= fill_idx_r;
        end
    end
`endif

    // Next-state logic, EXEC-cycle TLB strobes and result computation
    always_comb begin
        state_nxt_s    = state_r;
        tlb_s_vppn     = 19'd0;
        tlb_s_va_bit12 = 1'b0;
        tlb_s_asid     = 10'd0;
        tlb_we         = 1'b0;
        tlb_w_index    = 4'd0;
        tlb_w_entry    = 89'd0;
        tlb_r_index    = 4'd0;
        tlb_inv_valid  = 1'b0;
        tlb_inv_op     = 5'd0;
        res_ne_s       = 1'b0;
        res_err_s      = 1'b0;
        res_index_s    = 4'd0;
        res_entry_s    = 89'd0;
        case (state_r)
            ST_IDLE: begin
                if (req_valid) begin
                    state_nxt_s = ST_EXEC;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_nxt_s = ST_RESP;
                // Strobes are gated by reset so an aborted request never touches the TLB
                case (op_r)
                    OP_SRCH: begin
                        tlb_s_vppn = vppn_r;
                        tlb_s_asid = cur_asid_r;
                        if (tlb_s_found) begin
                            res_index_s = tlb_s_index;
                        end else begin
                            res_ne_s    = 1'b1;
                            res_index_s = idx_r;
                        end
                    end
                    OP_RD: begin
                        tlb_r_index = idx_r;
                        res_index_s = idx_r;
                        if (tlb_r_entry[88]) begin
                            res_entry_s = tlb_r_entry;
                        end else begin
                            res_ne_s = 1'b1;
                        end
                    end
                    OP_WR: begin
                        tlb_we      = ~reset;
                        tlb_w_index = idx_r;
                        tlb_w_entry = wentry_r;
                        res_index_s = idx_r;
                    end
                    OP_FILL: begin
                        tlb_we      = ~reset;
                        tlb_w_index = fill_idx_r;
                        tlb_w_entry = wentry_r;
                        res_index_s = fill_idx_r;
                    end
                    OP_INV: begin
                        tlb_s_vppn     = va_hi_r[19:1];
                        tlb_s_va_bit12 = va_hi_r[0];
                        tlb_s_asid     = asid_r;
                        if (inv_op_r <= 5'd6) begin
                            tlb_inv_valid = ~reset;
                            tlb_inv_op    = inv_op_r;
                        end else begin
                            res_err_s = 1'b1;
                        end
                    end
                    default: res_err_s = 1'b1;
                endcase
            end
            ST_RESP: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_tlb_ctrl.sv
// Directed self-checking bench for tlb_ctrl (default counter fill build).
module tb_tlb_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [4:0]  req_inv_op;
    logic [9:0]  req_asid;
    logic [31:0] req_va;
    logic [31:0] csr_tlbidx;
    logic [18:0] csr_tlbehi_vppn;
    logic [31:0] csr_tlbelo0, csr_tlbelo1;
    logic [9:0]  csr_asid;
    logic [18:0] tlb_s_vppn;
    logic        tlb_s_va_bit12;
    logic [9:0]  tlb_s_asid;
    logic        tlb_s_found;
    logic [3:0]  tlb_s_index;
    logic        tlb_we;
    logic [3:0]  tlb_w_index;
    logic [88:0] tlb_w_entry;
    logic [3:0]  tlb_r_index;
    logic [88:0] tlb_r_entry;
    logic        tlb_inv_valid;
    logic [4:0]  tlb_inv_op;
    logic        resp_valid;
    logic [2:0]  resp_op;
    logic        resp_ne;
    logic [3:0]  resp_index;
    logic [88:0] resp_entry;
    logic        resp_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    tlb_ctrl dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_inv_op(req_inv_op), .req_asid(req_asid), .req_va(req_va),
        .csr_tlbidx(csr_tlbidx), .csr_tlbehi_vppn(csr_tlbehi_vppn),
        .csr_tlbelo0(csr_tlbelo0), .csr_tlbelo1(csr_tlbelo1), .csr_asid(csr_asid),
        .tlb_s_vppn(tlb_s_vppn), .tlb_s_va_bit12(tlb_s_va_bit12), .tlb_s_asid(tlb_s_asid),
        .tlb_s_found(tlb_s_found), .tlb_s_index(tlb_s_index),
        .tlb_we(tlb_we), .tlb_w_index(tlb_w_index), .tlb_w_entry(tlb_w_entry),
        .tlb_r_index(tlb_r_index), .tlb_r_entry(tlb_r_entry),
        .tlb_inv_valid(tlb_inv_valid), .tlb_inv_op(tlb_inv_op),
        .resp_valid(resp_valid), .resp_op(resp_op), .resp_ne(resp_ne),
        .resp_index(resp_index), .resp_entry(resp_entry), .resp_err(resp_err)
    );

    // Presents one request for a single cycle; returns at the falling edge inside EXEC.
    task automatic start_req(input logic [2:0] op, input logic [4:0] iop,
                             input logic [9:0] asid, input logic [31:0] va);
        @(negedge clk);
        req_valid = 1'b1; req_op = op; req_inv_op = iop; req_asid = asid; req_va = va;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; req_valid = 1'b1; req_op = 3'd2;
        @(negedge clk); @(negedge clk);
        checks++;
        if ({resp_valid, resp_ne, resp_err, resp_op, resp_index, tlb_we, tlb_inv_valid} !== 12'd0 ||
            resp_entry !== 89'd0) begin
            errors++; $display("FAIL reset_outputs: resp_valid=%b we=%b inv=%b idx=%0d", resp_valid, tlb_we, tlb_inv_valid, resp_index);
        end
        req_valid = 1'b0; reset = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    endtask

    task automatic test_srch_hit;
        csr_tlbehi_vppn = 19'h12345; csr_asid = 10'h003; csr_tlbidx = 32'h0000_0002;
        tlb_s_found = 1'b1; tlb_s_index = 4'd5;
        start_req(3'd0, 5'd0, 10'h0, 32'h0);
        checks++;
        if (tlb_s_vppn !== 19'h12345 || tlb_s_asid !== 10'h003 || tlb_s_va_bit12 !== 1'b0 || req_ready !== 1'b0) begin
            errors++; $display("FAIL srch_exec: vppn=%h asid=%h b12=%b ready=%b", tlb_s_vppn, tlb_s_asid, tlb_s_va_bit12, req_ready);
        end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1 || resp_ne !== 1'b0 || resp_index !== 4'd5 || resp_op !== 3'd0 ||
            resp_err !== 1'b0 || resp_entry !== 89'd0) begin
            errors++; $display("FAIL srch_hit_resp: valid=%b ne=%b idx=%0d want 1/0/5", resp_valid, resp_ne, resp_index);
        end
        checks++;
        if (tlb_s_vppn !== 19'd0) begin errors++; $display("FAIL srch_s_idle: vppn=%h want 0", tlb_s_vppn); end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b0 || resp_index !== 4'd5 || req_ready !== 1'b1) begin
            errors++; $display("FAIL srch_hold: valid=%b idx=%0d ready=%b want 0/5/1", resp_valid, resp_index, req_ready);
        end
    endtask

    task automatic test_srch_miss;
        int strobes;
        strobes = 0;
        csr_tlbidx = 32'h0000_0009; tlb_s_found = 1'b0; tlb_s_index = 4'd5;
        start_req(3'd0, 5'd0, 10'h0, 32'h0);
        strobes += int'(tlb_we) + int'(tlb_inv_valid);
        @(negedge clk);
        strobes += int'(tlb_we) + int'(tlb_inv_valid);
        checks++;
        if (resp_valid !== 1'b1 || resp_ne !== 1'b1 || resp_index !== 4'd9) begin
            errors++; $display("FAIL srch_miss_resp: valid=%b ne=%b idx=%0d want 1/1/9", resp_valid, resp_ne, resp_index);
        end
        @(negedge clk);
        strobes += int'(tlb_we) + int'(tlb_inv_valid);
        checks++;
        if (strobes != 0) begin errors++; $display("FAIL srch_miss_strobes: got %0d want 0", strobes); end
    endtask

    task automatic test_write;
        logic [88:0] exp_e;
        exp_e = {1'b1, 19'h12345, 6'h0C, 10'h003, 1'b0,
                 20'hABCDE, 2'd3, 2'd1, 1'b1, 1'b1,
                 20'h12345, 2'd0, 2'd0, 1'b0, 1'b1};
        csr_tlbidx = 32'h0C00_0003; csr_tlbehi_vppn = 19'h12345; csr_asid = 10'h003;
        csr_tlbelo0 = 32'h0ABC_DE5F; csr_tlbelo1 = 32'h0123_4501;
        start_req(3'd2, 5'd0, 10'h0, 32'h0);
        checks++;
        if (tlb_we !== 1'b1 || tlb_inv_valid !== 1'b0 || tlb_w_index !== 4'd3 || tlb_w_entry !== exp_e) begin
            errors++; $display("FAIL wr_exec: we=%b idx=%0d entry=%h want 1/3/%h", tlb_we, tlb_w_index, tlb_w_entry, exp_e);
        end
        @(negedge clk);
        checks++;
        if (tlb_we !== 1'b0 || resp_valid !== 1'b1 || resp_index !== 4'd3 || resp_op !== 3'd2) begin
            errors++; $display("FAIL wr_resp: we=%b valid=%b idx=%0d op=%0d want 0/1/3/2", tlb_we, resp_valid, resp_index, resp_op);
        end
        @(negedge clk);
    endtask

    task automatic test_fill;
        csr_tlbidx = 32'h8500_0007;
        for (int k = 0; k < 17; k++) begin
            start_req(3'd3, 5'd0, 10'h0, 32'h0);
            checks++;
            if (tlb_we !== 1'b1 || tlb_w_index !== 4'(k % 16) || tlb_w_entry[88] !== 1'b0) begin
                errors++; $display("FAIL fill_%0d_exec: we=%b idx=%0d e=%b want 1/%0d/0", k, tlb_we, tlb_w_index, tlb_w_entry[88], k % 16);
            end
            @(negedge clk);
            checks++;
            if (tlb_we !== 1'b0 || resp_index !== 4'(k % 16)) begin
                errors++; $display("FAIL fill_%0d_resp: we=%b idx=%0d want 0/%0d", k, tlb_we, resp_index, k % 16);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_inv;
        int pulses;
        start_req(3'd4, 5'd7, 10'h155, 32'hDEAD_B000);
        checks++;
        if (tlb_inv_valid !== 1'b0 || tlb_we !== 1'b0) begin errors++; $display("FAIL inv7_exec: inv=%b want 0", tlb_inv_valid); end
        @(negedge clk);
        checks++;
        if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_op !== 3'd4) begin
            errors++; $display("FAIL inv7_resp: valid=%b err=%b want 1/1", resp_valid, resp_err);
        end
        @(negedge clk);
        pulses = 0;
        start_req(3'd4, 5'd5, 10'h155, 32'hDEAD_B000);
        pulses += int'(tlb_inv_valid);
        checks++;
        if (tlb_inv_valid !== 1'b1 || tlb_inv_op !== 5'd5 || tlb_s_vppn !== 19'h6F56D ||
            tlb_s_va_bit12 !== 1'b1 || tlb_s_asid !== 10'h155 || tlb_we !== 1'b0) begin
            errors++; $display("FAIL inv5_exec: inv=%b op=%0d vppn=%h b12=%b asid=%h want 1/5/6f56d/1/155", tlb_inv_valid, tlb_inv_op, tlb_s_vppn, tlb_s_va_bit12, tlb_s_asid);
        end
        @(negedge clk);
        pulses += int'(tlb_inv_valid);
        checks++;
        if (resp_err !== 1'b0 || resp_valid !== 1'b1) begin errors++; $display("FAIL inv5_resp: err=%b valid=%b want 0/1", resp_err, resp_valid); end
        @(negedge clk);
        pulses += int'(tlb_inv_valid);
        checks++;
        if (pulses != 1) begin errors++; $display("FAIL inv5_pulses: got %0d want 1", pulses); end
        start_req(3'd6, 5'd0, 10'h0, 32'h0);
        checks++;
        if (tlb_we !== 1'b0 || tlb_inv_valid !== 1'b0) begin errors++; $display("FAIL op6_exec: we=%b inv=%b want 0/0", tlb_we, tlb_inv_valid); end
        @(negedge clk);
        checks++;
        if (resp_err !== 1'b1 || resp_op !== 3'd6) begin errors++; $display("FAIL op6_resp: err=%b op=%0d want 1/6", resp_err, resp_op); end
        @(negedge clk);
    endtask

    task automatic test_reset_exec;
        int seen;
        seen = 0;
        csr_tlbidx = 32'h0000_0004;
        start_req(3'd2, 5'd0, 10'h0, 32'h0);
        reset = 1'b1;
        #1;
        checks++;
        if (tlb_we !== 1'b0) begin errors++; $display("FAIL rst_exec_we: got %b want 0", tlb_we); end
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL rst_exec_next: ready=%b valid=%b want 1/0", req_ready, resp_valid);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            seen += int'(resp_valid) + int'(tlb_we);
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL rst_exec_after: got %0d events want 0", seen); end
    endtask

    task automatic test_rd_held;
        int resps;
        resps = 0;
        csr_tlbidx = 32'h0000_0006;
        tlb_r_entry = {1'b0, 19'h1ABCD, 69'h1};
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd1;
        @(negedge clk);
        checks++;
        if (tlb_r_index !== 4'd6 || req_ready !== 1'b0) begin
            errors++; $display("FAIL rd_exec: ridx=%0d ready=%b want 6/0", tlb_r_index, req_ready);
        end
        @(negedge clk);
        resps += int'(resp_valid);
        checks++;
        if (resp_valid !== 1'b1 || resp_ne !== 1'b1 || resp_entry !== 89'd0) begin
            errors++; $display("FAIL rd_e0_resp: valid=%b ne=%b entry=%h want 1/1/0", resp_valid, resp_ne, resp_entry);
        end
        req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            resps += int'(resp_valid);
        end
        checks++;
        if (resps != 1) begin errors++; $display("FAIL rd_held_once: got %0d responses want 1", resps); end
        tlb_r_entry = {1'b1, 19'h0BEEF, 69'h15};
        start_req(3'd1, 5'd0, 10'h0, 32'h0);
        @(negedge clk);
        checks++;
        if (resp_ne !== 1'b0 || resp_entry !== {1'b1, 19'h0BEEF, 69'h15}) begin
            errors++; $display("FAIL rd_e1_resp: ne=%b entry=%h", resp_ne, resp_entry);
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_inv_op = 5'd0; req_asid = 10'd0; req_va = 32'd0;
        csr_tlbidx = 32'd0; csr_tlbehi_vppn = 19'd0; csr_tlbelo0 = 32'd0; csr_tlbelo1 = 32'd0; csr_asid = 10'd0;
        tlb_s_found = 1'b0; tlb_s_index = 4'd0; tlb_r_entry = 89'd0;
        test_reset();
        test_srch_hit();
        test_srch_miss();
        test_fill();
        test_write();
        test_inv();
        test_reset_exec();
        test_rd_held();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tlb_ctrl.md
TLB_CTRL -- requirements
Module: tlb_ctrl

Interface
REQ-001 The module SHALL use one clock and a synchronous active-high reset: clk  in  1  clock; reset  in  1  synchronous, active-high.
REQ-002 The module SHALL have the following request-side ports:
- req_valid  in  1  operation request.
- req_ready  out  1  request accepted when high with req_valid.
- req_op  in  3  0=SRCH, 1=RD, 2=WR, 3=FILL, 4=INV; 5-7 illegal.
- req_inv_op  in  5  invtlb op.
- req_asid  in  10  invtlb ASID.
- req_va  in  32  invtlb VA.
REQ-003 The module SHALL have the following CSR input ports:
- csr_tlbidx  in  32  index[3:0], ps[29:24], ne[31].
- csr_tlbehi_vppn  in  19  VPPN.
- csr_tlbelo0, csr_tlbelo1  in  32  each: V[0], D[1], PLV[3:2], MAT[5:4], G[6], PPN[27:8].
- csr_asid  in  10  current ASID.
REQ-004 The module SHALL have the following TLB-side ports:
- tlb_s_vppn  out  19.
- tlb_s_va_bit12  out  1.
- tlb_s_asid  out  10.
- tlb_s_found  in  1.
- tlb_s_index  in  4.
- tlb_we  out  1.
- tlb_w_index  out  4.
- tlb_w_entry  out  89.
- tlb_r_index  out  4.
- tlb_r_entry  in  89.
- tlb_inv_valid  out  1.
- tlb_inv_op  out  5.
REQ-005 The 89-bit entry SHALL be packed MSB to LSB as {e, vppn[18:0], ps[5:0], asid[9:0], g, ppn0[19:0], plv0, mat0, d0, v0, ppn1[19:0], plv1, mat1, d1, v1}.
REQ-006 The module SHALL have the following response ports:
- resp_valid  out  1  one-cycle result pulse.
- resp_op  out  3.
- resp_ne  out  1.
- resp_index  out  4.
- resp_entry  out  89.
- resp_err  out  1  illegal op.

Function
REQ-007 The FSM SHALL have three states, IDLE, EXEC and RESP; req_ready SHALL be 1 only in IDLE.
REQ-008 On req_valid&&req_ready at cycle T, the module SHALL latch all req_* and csr_* inputs, enter EXEC at T+1 and RESP at T+2, and return to IDLE at T+3.
REQ-009 resp_valid SHALL be 1 only in RESP, and resp_* SHALL hold their values until the next RESP.
REQ-010 Requests presented while not in IDLE SHALL be ignored.
REQ-011 In EXEC, tlb_s_* SHALL be driven from latched values: for SRCH, vppn=tlbehi_vppn, asid=csr_asid, va_bit12=0; for INV, vppn=va[31:13], asid=req_asid, va_bit12=va[12]. In other states tlb_s_* SHALL be 0.
REQ-012 SRCH: if tlb_s_found, resp_ne=0 and resp_index=tlb_s_index; otherwise resp_ne=1 and resp_index=latched tlbidx.index. resp_entry SHALL be 0.
REQ-013 RD: tlb_r_index=latched tlbidx.index in EXEC. If the entry's e bit is 1, resp_entry=tlb_r_entry and resp_ne=0; otherwise resp_entry=0 and resp_ne=1.
REQ-014 WR/FILL: the module SHALL pulse tlb_we for exactly one cycle, in EXEC. The written entry SHALL be:
- e=~ne.
- vppn=tlbehi_vppn.
- ps=tlbidx.ps.
- asid=csr_asid.
- g=elo0.G&elo1.G.
- remaining fields from elo0/elo1.
REQ-015 tlb_w_index SHALL be tlbidx.index for WR and the fill index for FILL; resp_index SHALL report the index written.
REQ-016 INV with req_inv_op<=6 SHALL pulse tlb_inv_valid for one cycle in EXEC, with tlb_inv_op=req_inv_op.
REQ-017 INV with req_inv_op>6, or any req_op>=5, SHALL issue no TLB action and SHALL set resp_err=1. resp_err SHALL be 0 otherwise.
REQ-018 tlb_we and tlb_inv_valid SHALL never be asserted in the same cycle.

Reset
REQ-019 Reset SHALL force IDLE with req_ready=1 on the following cycle.
REQ-020 Reset SHALL clear resp_valid, resp_ne, resp_err, resp_index, resp_entry, resp_op, tlb_we and tlb_inv_valid to 0.
REQ-021 Reset asserted during EXEC SHALL suppress any tlb_we or tlb_inv_valid from that cycle onward, and no response SHALL be produced for the aborted request.

Configuration
REQ-022 With TLB_FILL_LFSR_EN defined, the fill index SHALL come from a 4-bit LFSR using x^4+x^3+1, reset to 4'b0001 and advancing every clock.
REQ-023 Without TLB_FILL_LFSR_EN, the fill index SHALL come from a 4-bit counter, reset to 0 and incremented by one after each FILL, wrapping 15->0.

Verification
REQ-024 SRCH hit: entry 5 holds vppn=0x12345 with asid=0x3 -> resp at T+2 with ne=0 and index=5.
REQ-025 SRCH miss with tlbidx.index=9 -> ne=1 and index=9; tlb_we and tlb_inv_valid stay 0 throughout.
REQ-026 Counter build: three FILLs after reset -> tlb_w_index=0, 1, 2, each with a single-cycle tlb_we; the 17th FILL writes index 0 (wrap).
REQ-027 INV with op=7 -> resp_err=1 and no tlb_inv_valid; INV with op=5 -> one tlb_inv_valid pulse with tlb_inv_op=5 and tlb_s_vppn=req_va[31:13].
REQ-028 Reset asserted in the EXEC cycle of a WR -> no tlb_we and no resp_valid; req_ready=1 on the next cycle.
REQ-029 RD of an entry with e=0 -> ne=1 and resp_entry=0; a held req_valid during EXEC/RESP is accepted exactly once.
